// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: alignment mode encodings and
// the default counter/compare width.
package pwm_pkg;

    localparam int PWM_WIDTH = 16;

    localparam logic [1:0] ALIGN_LEFT  = 2'b00;
    localparam logic [1:0] ALIGN_RIGHT = 2'b01;
    localparam logic [1:0] ALIGN_RANGE = 2'b10;

endpackage : pwm_pkg

// File: rtl/pwm_wrap_detect.sv
// Period boundary detector: remembers last cycle's counter value and flags the
// cycle in which the counter lands on its start value for the current direction.
module pwm_wrap_detect
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count_val,
    input  logic [WIDTH-1:0] period,
    input  logic             upnotdown,
    output logic             wrap
);

    logic [WIDTH-1:0] count_prev;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_prev <= '0;
        end else begin
            count_prev <= count_val;
        end
    end

    // A frozen counter (or period 0) never changes value, so it never wraps;
    // a counter reset to 0 while counting up does count as a boundary.
    always_comb begin
        wrap = 1'b0;
        if (count_val != count_prev) begin
            if (upnotdown) begin
                wrap = (count_val == '0);
            end else begin
                wrap = (count_val == period);
            end
        end
    end

endmodule : pwm_wrap_detect

// File: rtl/pwm_gen.sv
// PWM output stage: double-buffered compare/alignment settings that update only
// at a period boundary or enable rise, plus registered output and period pulse.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_en,
    input  logic [WIDTH-1:0] count_val,
    input  logic [WIDTH-1:0] period,
    input  logic             upnotdown,
    input  logic [WIDTH-1:0] compare1,
    input  logic [WIDTH-1:0] compare2,
    input  logic [1:0]       align_mode,
    input  logic             polarity,
    output logic             pwm_out,
    output logic             period_irq
);

    logic             wrap;
    logic             pwm_en_prev;
    logic             en_rise;
    logic             load;

    logic [WIDTH-1:0] cmp1_sh;
    logic [WIDTH-1:0] cmp2_sh;
    logic [1:0]       mode_sh;

    logic [WIDTH-1:0] cmp1_eff;
    logic [WIDTH-1:0] cmp2_eff;
    logic [1:0]       mode_eff;
    logic             active;

    pwm_wrap_detect #(
        .WIDTH (WIDTH)
    ) u_wrap_detect (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_val (count_val),
        .period    (period),
        .upnotdown (upnotdown),
        .wrap      (wrap)
    );

    assign en_rise = pwm_en && !pwm_en_prev;
    assign load    = wrap || en_rise;

    // NOTE: the shadows are a handful of flops, not a memory, so they take a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_en_prev <= 1'b0;
            cmp1_sh     <= '0;
            cmp2_sh     <= '0;
            mode_sh     <= ALIGN_LEFT;
        end else begin
            pwm_en_prev <= pwm_en;
            if (load) begin
                cmp1_sh <= compare1;
                cmp2_sh <= compare2;
                mode_sh <= align_mode;
            end
        end
    end

    // In a load cycle the live settings bypass the shadows so the new
    // waveform starts exactly on the boundary count.
    assign cmp1_eff = load ? compare1   : cmp1_sh;
    assign cmp2_eff = load ? compare2   : cmp2_sh;
    assign mode_eff = load ? align_mode : mode_sh;

    // NOTE: active gets a default before the case so no latch is inferred.
    always_comb begin
        active = 1'b0;
        case (mode_eff)
            ALIGN_RIGHT: active = (count_val >= cmp1_eff);
            // An empty or inverted window (cmp1 >= cmp2) can never be satisfied.
            ALIGN_RANGE: active = (count_val >= cmp1_eff) && (count_val < cmp2_eff);
            default:     active = (count_val < cmp1_eff);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out    <= 1'b0;
            period_irq <= 1'b0;
        end else begin
            pwm_out    <= pwm_en ? (active ^ polarity) : polarity;
            period_irq <= wrap && pwm_en;
        end
    end

endmodule : pwm_gen

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: the bench plays the role of the timebase counter
// and checks pwm_out/period_irq against hand-derived waveform values.
module tb_pwm_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm_en;
    logic [15:0] count_val;
    logic [15:0] period;
    logic        upnotdown;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [1:0]  align_mode;
    logic        polarity;
    logic        pwm_out;
    logic        period_irq;

    int total = 0;
    int bad   = 0;

    pwm_gen #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_en     (pwm_en),
        .count_val  (count_val),
        .period     (period),
        .upnotdown  (upnotdown),
        .compare1   (compare1),
        .compare2   (compare2),
        .align_mode (align_mode),
        .polarity   (polarity),
        .pwm_out    (pwm_out),
        .period_irq (period_irq)
    );

    always #5 clk = ~clk;

    // Present one counter value, let one edge pass, land 1 ns after it.
    task automatic drive(input logic [15:0] c);
        count_val = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pwm_en = 1'b0; count_val = '0; period = 16'd9;
        upnotdown = 1'b1; compare1 = '0; compare2 = '0;
        align_mode = 2'b00; polarity = 1'b1;
        #3;
        total++;
        if ({pwm_out, period_irq} !== 2'b00) begin
            bad++;
            $display("FAIL reset_async: out=%b irq=%b want 0 0", pwm_out, period_irq);
        end
        @(posedge clk); #1;
        total++;
        if ({pwm_out, period_irq} !== 2'b00) begin
            bad++;
            $display("FAIL reset_held: out=%b irq=%b want 0 0", pwm_out, period_irq);
        end
        rst_n = 1'b1;
        polarity = 1'b0;
    endtask

    task automatic test_left_duty;
        int pulses = 0;
        compare1 = 16'd3; align_mode = 2'b00; pwm_en = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            logic [15:0] c;
            logic e_out, e_irq;
            c = 16'(k % 10);
            drive(c);
            e_out = (c < 3);
            e_irq = (c == 0) && (k > 0);
            if (period_irq) pulses++;
            total++;
            if ({pwm_out, period_irq} !== {e_out, e_irq}) begin
                bad++;
                $display("FAIL left_duty k=%0d cnt=%0d: out=%b irq=%b want %b %b",
                         k, c, pwm_out, period_irq, e_out, e_irq);
            end
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL left_irq_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_double_buffer;
        // Count is at 0 with cmp1=3; rewrite compare1 to 7 at count 5.
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) compare1 = 16'd7;
            drive(16'(c));
            total++;
            if (pwm_out !== (c < 3)) begin
                bad++;
                $display("FAIL dbuf_old cnt=%0d: out=%b want %b", c, pwm_out, (c < 3));
            end
        end
        for (int c = 0; c <= 9; c++) begin
            drive(16'(c));
            total++;
            if ({pwm_out, period_irq} !== {1'(c < 7), 1'(c == 0)}) begin
                bad++;
                $display("FAIL dbuf_new cnt=%0d: out=%b irq=%b want %b %b",
                         c, pwm_out, period_irq, (c < 7), (c == 0));
            end
        end
    endtask

    task automatic test_range_down;
        // New settings are live now but only load at the down-count boundary (9).
        align_mode = 2'b10; compare1 = 16'd2; compare2 = 16'd6; upnotdown = 1'b0;
        for (int c = 8; c >= 0; c--) begin
            drive(16'(c));
            total++;
            if ({pwm_out, period_irq} !== {1'(c < 7), 1'b0}) begin
                bad++;
                $display("FAIL range_pre cnt=%0d: out=%b irq=%b want %b 0",
                         c, pwm_out, period_irq, (c < 7));
            end
        end
        for (int c = 9; c >= 0; c--) begin
            logic e_out;
            e_out = (c >= 2) && (c <= 5);
            drive(16'(c));
            total++;
            if ({pwm_out, period_irq} !== {e_out, 1'(c == 9)}) begin
                bad++;
                $display("FAIL range_down cnt=%0d: out=%b irq=%b want %b %b",
                         c, pwm_out, period_irq, e_out, (c == 9));
            end
        end
        compare1 = 16'd6; compare2 = 16'd2;
        for (int c = 9; c >= 0; c--) begin
            drive(16'(c));
            total++;
            if (pwm_out !== 1'b0) begin
                bad++;
                $display("FAIL range_inverted cnt=%0d: out=%b want 0", c, pwm_out);
            end
        end
    endtask

    task automatic test_extremes;
        upnotdown = 1'b1; align_mode = 2'b00;
        drive(16'd9);
        // cases: cmp1=0/pol0 -> 0, cmp1=10/pol0 -> 1, cmp1=0/pol1 -> 1, cmp1=10/pol1 -> 0
        for (int i = 0; i < 4; i++) begin
            logic e_out;
            compare1 = (i % 2) ? 16'd10 : 16'd0;
            polarity = 1'(i / 2);
            e_out    = 1'(i % 2) ^ polarity;
            for (int c = 0; c <= 9; c++) begin
                drive(16'(c));
                total++;
                if ({pwm_out, period_irq} !== {e_out, 1'(c == 0)}) begin
                    bad++;
                    $display("FAIL extreme case=%0d cnt=%0d: out=%b irq=%b want %b %b",
                             i, c, pwm_out, period_irq, e_out, (c == 0));
                end
            end
        end
    endtask

    task automatic test_enable_and_async_reset;
        polarity = 1'b0; compare1 = 16'd3;
        drive(16'd0);
        drive(16'd1);
        total++;
        if (pwm_out !== 1'b1) begin
            bad++; $display("FAIL en_before_drop: out=%b want 1", pwm_out);
        end
        pwm_en = 1'b0;
        drive(16'd2);
        total++;
        if ({pwm_out, period_irq} !== 2'b00) begin
            bad++; $display("FAIL en_drop: out=%b irq=%b want 0 0", pwm_out, period_irq);
        end
        polarity = 1'b1;
        drive(16'd3);
        total++;
        if (pwm_out !== 1'b1) begin
            bad++; $display("FAIL en_off_pol1: out=%b want 1", pwm_out);
        end
        polarity = 1'b0; compare1 = 16'd8; pwm_en = 1'b1;
        for (int c = 4; c <= 8; c++) begin
            drive(16'(c));
            total++;
            if (pwm_out !== (c < 8)) begin
                bad++;
                $display("FAIL en_rise_load cnt=%0d: out=%b want %b", c, pwm_out, (c < 8));
            end
        end
        pwm_en = 1'b0;
        drive(16'd9);
        drive(16'd0);
        total++;
        if ({pwm_out, period_irq} !== 2'b00) begin
            bad++; $display("FAIL wrap_while_off: out=%b irq=%b want 0 0", pwm_out, period_irq);
        end
        pwm_en = 1'b1;
        for (int c = 1; c <= 9; c++) drive(16'(c));
        drive(16'd0);
        total++;
        if ({pwm_out, period_irq} !== 2'b11) begin
            bad++; $display("FAIL pre_reset: out=%b irq=%b want 1 1", pwm_out, period_irq);
        end
        rst_n = 1'b0;
        #2;
        total++;
        if ({pwm_out, period_irq} !== 2'b00) begin
            bad++; $display("FAIL async_reset: out=%b irq=%b want 0 0", pwm_out, period_irq);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_counter_reset;
        int pulses = 0;
        compare1 = 16'd3; align_mode = 2'b00; polarity = 1'b0; upnotdown = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c == 4) compare1 = 16'd5;
            drive(16'(c));
            total++;
            if ({pwm_out, period_irq} !== {1'(c < 3), 1'b0}) begin
                bad++;
                $display("FAIL cnt_reset_pre cnt=%0d: out=%b irq=%b want %b 0",
                         c, pwm_out, period_irq, (c < 3));
            end
        end
        for (int c = 0; c <= 6; c++) begin
            drive(16'(c));
            if (period_irq) pulses++;
            total++;
            if ({pwm_out, period_irq} !== {1'(c < 5), 1'(c == 0)}) begin
                bad++;
                $display("FAIL cnt_reset_post cnt=%0d: out=%b irq=%b want %b %b",
                         c, pwm_out, period_irq, (c < 5), (c == 0));
            end
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL cnt_reset_irq_count: got %0d want 1", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_left_duty();
        test_double_buffer();
        test_range_down();
        test_extremes();
        test_enable_and_async_reset();
        test_counter_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_gen

// File: doc/pwm_gen.md
# pwm_gen

PWM output stage that reads the shared timebase counter's `count_val` and turns it into a PWM waveform. It sits downstream of the prescaled up/down counter, alongside the register file. Compare and alignment settings are double-buffered and take effect only at a counter period boundary, so a waveform never glitches mid-period. It also emits a one-cycle period interrupt pulse at every detected boundary.

## Interface
Parameters:
- `WIDTH`, 16: counter and compare width; must match the counter's `count_val`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  peripheral clock, same clock as the counter.
- `rst_n`  in  1  asynchronous active-low reset.
- `pwm_en`  in  1  output enable; 0 forces the inactive level.
- `count_val`  in  WIDTH  live counter value.
- `period`  in  WIDTH  live period register, the same value the counter uses.
- `upnotdown`  in  1  counter direction: 1 = up.
- `compare1`  in  WIDTH  first compare register, live.
- `compare2`  in  WIDTH  second compare register, live; used only in range mode.
- `align_mode`  in  2  waveform mode, live: 00 = left, 01 = right, 10 = range, 11 = reserved (behaves as left).
- `polarity`  in  1  0 = active-high, 1 = active-low.
- `pwm_out`  out  1  registered PWM output.
- `period_irq`  out  1  one-cycle pulse, registered, on each boundary.

## Operation
- `count_prev` register holds the previous cycle's `count_val`.
- Boundary event `wrap`: `count_val != count_prev` AND one of the following:
  - `upnotdown` = 1 and `count_val == 0`;
  - `upnotdown` = 0 and `count_val == period`.
- Shadow registers `cmp1_sh`, `cmp2_sh` and `mode_sh` load from the live inputs when either condition holds:
  - `wrap` is high;
  - `pwm_en` rises (was 0 last cycle, is 1 now).
- Effective settings in a load cycle are the live inputs (bypass); otherwise they are the shadows.
- Active condition, using effective settings and unsigned compares:
  - left: `count_val < cmp1`.
  - right: `count_val >= cmp1`.
  - range: `cmp1 <= count_val < cmp2`. If `cmp1 >= cmp2`, never active.
- `pwm_out` next value:
  - `pwm_en` = 1: `active XOR polarity`.
  - `pwm_en` = 0: `polarity` (the inactive level).
- `period_irq` next value: `wrap AND pwm_en`.
- Boundaries:
  - left mode, `cmp1 == 0`: 0 % duty.
  - left mode, `cmp1 > period`: 100 % duty.
  - right mode, `cmp1 == 0`: 100 % duty.
  - `period == 0`: `count_val` never changes, so no `wrap` occurs and shadows hold. The output follows the held settings evaluated at count 0.
  - Counter frozen (its `en` = 0): `count_val` is constant, so there is no `wrap` and the output is static.
  - Counter reset mid-period while counting up: the drop to 0 is a change to 0, so it counts as `wrap`. Shadows reload and `period_irq` fires.
  - Direction flip: the `wrap` rule is evaluated with the current `upnotdown`, with no extra event.
  - Live register writes mid-period: no effect on `pwm_out` until the next `wrap` or `pwm_en` rise.

## Timing
- Reset values: `pwm_out` = 0, `period_irq` = 0, `count_prev` = 0, all shadows = 0.
- Latency: `count_val` in cycle N is reflected on `pwm_out` at cycle N+1. `period_irq` goes high in cycle N+1 for a `wrap` in cycle N, for exactly one cycle.
- `pwm_en` 1→0 in cycle N: `pwm_out` equals `polarity` from N+1.
- `pwm_en` 0→1 in cycle N: shadows load in N, and the waveform uses the new settings from N+1.
- Assertion of `rst_n` forces all outputs low immediately, independent of `clk`. No other handshakes.

## Structure
- `pwm_pkg` holds:
  - the `align_mode` encodings as localparams: `ALIGN_LEFT`, `ALIGN_RIGHT`, `ALIGN_RANGE`;
  - the `WIDTH` default.
- Sub-module `pwm_wrap_detect` holds `count_prev` and computes `wrap`.
- The shadow registers, compare logic and output flops stay in `pwm_gen`.

## Test plan
- Left-aligned duty: `period` = 9, up counting, `compare1` = 3, `polarity` = 0, `pwm_en` = 1. Required: `pwm_out` is high for counts 0–2 and low for counts 3–9, each seen one cycle later. `period_irq` pulses once per 10 counts.
- Double buffering: change `compare1` from 3 to 7 while `count_val` = 5. Required: the current period keeps 3. Starting at the next count 0, `pwm_out` is high for counts 0–6.
- Range mode with down counting: `compare1` = 2, `compare2` = 6, counting 9→0. Required: high for counts 5 down to 2. With `compare1` = 6 and `compare2` = 2, `pwm_out` stays low.
- Extremes: left mode with `compare1` = 0 gives a constant 0. Left mode with `compare1` = 10 and `period` = 9 gives a constant 1. `polarity` = 1 inverts both results.
- Enable and reset: drop `pwm_en` mid-period, and `pwm_out` equals `polarity` the next cycle. Raise `pwm_en`, and the new `compare1` takes effect at once. Assert `rst_n` mid-period, and `pwm_out` and `period_irq` go to 0 asynchronously.
- Counter reset: pulse the counter reset at count 6 (up counting). Required: `wrap` is detected, shadows reload, and `period_irq` pulses once.
